// File: rtl/ntt_bitrev_reorder.sv
// Ping-pong reorder buffer: writes each N-sample frame bit-reversed (or linear on bypass) and reads it out in natural order.
// Latency in_start -> out_start is N+DELAY_BRAM cycles; no backpressure, one sample per clock in and out.
module ntt_bitrev_reorder #(
    parameter int LOGQ       = 32,
    parameter int LOGN       = 10,
    parameter int DELAY_BRAM = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_start,
    input  logic            bypass,
    input  logic [LOGQ-1:0] din,
    output logic            out_start,
    output logic            out_valid,
    output logic [LOGQ-1:0] dout,
    output logic            busy,
    output logic            frame_drop
);

    localparam int N = 1 << LOGN;

    typedef enum logic {W_IDLE, W_FILL}  wstate_t;
    typedef enum logic {R_IDLE, R_DRAIN} rstate_t;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = a[LOGN-1-i];
        end
        return r;
    endfunction

    wstate_t         wstate_q, wstate_d;
    logic [LOGN-1:0] wcnt_q, wcnt_d;
    logic            wbyp_q, wbyp_d;
    logic            wbank_q, wbank_d;

    rstate_t         rstate_q, rstate_d;
    logic [LOGN-1:0] rcnt_q, rcnt_d;
    logic            rbank_q, rbank_d;

    logic [DELAY_BRAM-1:0] vld_q;
    logic [DELAY_BRAM-1:0] sop_q;
    logic [LOGQ-1:0]       dat_q [DELAY_BRAM];

    logic [LOGQ-1:0] mem [2*N];

    logic            we;
    logic [LOGN-1:0] waddr;
    logic            wr_done;
    logic            ren;
    logic            rsop;

    always_comb begin
        wstate_d   = wstate_q;
        wcnt_d     = wcnt_q;
        wbyp_d     = wbyp_q;
        wbank_d    = wbank_q;
        we         = 1'b0;
        waddr      = '0;
        wr_done    = 1'b0;
        frame_drop = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (in_start) begin
                    we       = 1'b1;
                    wbyp_d   = bypass;
                    wcnt_d   = LOGN'(1);
                    wstate_d = W_FILL;
                end
            end
            W_FILL: begin
                we = 1'b1;
                if (wcnt_q == '1) begin
                    // Last sample: in_start here is not a restart, the next frame begins next cycle.
                    waddr    = wcnt_q;
                    wr_done  = 1'b1;
                    wbank_d  = ~wbank_q;
                    wcnt_d   = '0;
                    wstate_d = W_IDLE;
                end else if (in_start) begin
                    frame_drop = 1'b1;
                    wbyp_d     = bypass;
                    wcnt_d     = LOGN'(1);
                end else begin
                    waddr  = wbyp_q ? wcnt_q : bitrev(wcnt_q);
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rcnt_d   = rcnt_q;
        rbank_d  = rbank_q;
        ren      = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (wr_done) begin
                    rstate_d = R_DRAIN;
                    rcnt_d   = '0;
                    rbank_d  = wbank_q;
                end
            end
            R_DRAIN: begin
                ren = 1'b1;
                if (rcnt_q == '1) begin
                    rcnt_d = '0;
                    if (wr_done) begin
                        rbank_d = wbank_q;
                    end else begin
                        rstate_d = R_IDLE;
                    end
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    assign rsop = ren && (rcnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wstate_q <= W_IDLE;
            wcnt_q   <= '0;
            wbyp_q   <= 1'b0;
            wbank_q  <= 1'b0;
            rstate_q <= R_IDLE;
            rcnt_q   <= '0;
            rbank_q  <= 1'b0;
            vld_q    <= '0;
            sop_q    <= '0;
            for (int i = 0; i < DELAY_BRAM; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            wstate_q <= wstate_d;
            wcnt_q   <= wcnt_d;
            wbyp_q   <= wbyp_d;
            wbank_q  <= wbank_d;
            rstate_q <= rstate_d;
            rcnt_q   <= rcnt_d;
            rbank_q  <= rbank_d;
            vld_q[0] <= ren;
            sop_q[0] <= rsop;
            dat_q[0] <= mem[{rbank_q, rcnt_q}];
            for (int i = 1; i < DELAY_BRAM; i++) begin
                vld_q[i] <= vld_q[i-1];
                sop_q[i] <= sop_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    // Buffer storage carries no reset; stale words are never emitted because valid is gated.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wbank_q, waddr}] <= din;
        end
    end

    assign out_valid = vld_q[DELAY_BRAM-1];
    assign out_start = sop_q[DELAY_BRAM-1];
    assign dout      = out_valid ? dat_q[DELAY_BRAM-1] : '0;
    assign busy      = (wstate_q != W_IDLE) || (rstate_q != R_IDLE) || (|vld_q);

endmodule
